// File: rtl/jk_div_pkg.sv
// Shared types for the JK clock-divider controller: FSM states and {J,K} opcodes.
package jk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

endpackage

// File: rtl/jk_ff.sv
// Rising-edge JK flip-flop with asynchronous active-low reset to 0.
module jk_ff
  import jk_div_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD: q <= q;
        JK_CLR:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_div_ctrl.sv
// Burst clock-divider sequencer driving a single JK flop.
// Build option: JK_DIV_CONT_EN makes pulses==0 a continuous run instead of an error.
//
// Handshake: start/stop are level requests sampled on the rising clock edge; start is
// honoured only in IDLE with stop low, stop only in RUN (in IDLE it masks start).
module jk_div_ctrl
  import jk_div_pkg::*;
#(
  parameter int CNT_W = 5,
  parameter int PW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] div_n,
  input  logic [PW-1:0]    pulses,
  output logic             q,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state, state_n;
  logic [CNT_W-1:0] hcnt, hcnt_n, div_l;
  logic [PW-1:0]    pcnt, pcnt_n, pulses_l;
  logic [1:0]       jk;
  logic             load, err_n, bad_cfg, cont;

`ifdef JK_DIV_CONT_EN
  assign bad_cfg = (div_n == '0);
  assign cont    = (pulses_l == '0);
`else
  assign bad_cfg = (div_n == '0) || (pulses == '0);
  assign cont    = 1'b0;
`endif

  always_comb begin
    state_n = state;
    hcnt_n  = hcnt;
    pcnt_n  = pcnt;
    jk      = JK_HOLD;
    load    = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        jk = JK_CLR;
        if (start && !stop) begin
          if (bad_cfg) begin
            err_n = 1'b1;
          end else begin
            load    = 1'b1;
            hcnt_n  = '0;
            pcnt_n  = '0;
            state_n = RUN;
          end
        end
      end
      RUN: begin
        if (stop) begin
          jk      = JK_CLR;
          state_n = IDLE;
        end else if (hcnt == div_l - CNT_W'(1)) begin
          jk     = JK_TOG;
          hcnt_n = '0;
          // q currently high means this toggle is a falling edge: one period complete
          if (q && !cont) begin
            if (pcnt == pulses_l - PW'(1)) state_n = DONE;
            else                           pcnt_n  = pcnt + PW'(1);
          end
        end else begin
          hcnt_n = hcnt + CNT_W'(1);
        end
      end
      DONE: begin
        jk      = JK_CLR;
        state_n = IDLE;
      end
      default: begin
        jk      = JK_CLR;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hcnt     <= '0;
      pcnt     <= '0;
      div_l    <= '0;
      pulses_l <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_n;
      hcnt  <= hcnt_n;
      pcnt  <= pcnt_n;
      err   <= err_n;
      if (load) begin
        div_l    <= div_n;
        pulses_l <= pulses;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  jk_ff u_ff (
    .clk   (clk),
    .rst_n (rst_n),
    .j     (jk[1]),
    .k     (jk[0]),
    .q     (q)
  );

endmodule

// File: tb/tb_jk_div_ctrl.sv
// Directed and randomized bench for jk_div_ctrl; expected waveforms come from the burst timing rules.
module tb_jk_div_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [4:0] div_n = '0;
  logic [7:0] pulses = '0;
  logic       q, busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  jk_div_ctrl #(.CNT_W(5), .PW(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .stop   (stop),
    .div_n  (div_n),
    .pulses (pulses),
    .q      (q),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic eq, input logic eb,
                         input logic ed, input logic ee);
    chk({tag, ".q"},    32'(q),    32'(eq));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(ed));
    chk({tag, ".err"},  32'(err),  32'(ee));
  endtask

  // Launch a burst at the next edge (E0) and check every cycle until it is over.
  // s > 0 requests an abort sampled at E0+s; p == 0 is a continuous run (only with the macro).
  // noise: pulse start and scramble div_n/pulses while the burst owns the flop.
  task automatic burst(input string tag, input int d, input int p, input int s, input bit noise);
    int  last, half;
    bit  cont;
    logic eq, eb, ed;
    cont = (p == 0);
    last = (s > 0) ? s + 1 : 2 * d * p + 1;
    div_n  = 5'(d);
    pulses = 8'(p);
    start  = 1'b1;
    stop   = 1'b0;
    step();
    start = 1'b0;
    for (int k = 0; k <= last; k++) begin
      if (s > 0 && k >= s) begin
        eq = 1'b0; eb = 1'b0; ed = 1'b0;
      end else if (!cont && k >= 2 * d * p) begin
        eq = 1'b0; eb = 1'b0; ed = (k == 2 * d * p);
      end else begin
        half = k / d;
        eq = half[0]; eb = 1'b1; ed = 1'b0;
      end
      chk_all($sformatf("%s.k%0d", tag, k), eq, eb, ed, 1'b0);
      if (k == last) break;
      start = 1'b0;
      if (noise && (s == 0 || k + 1 <= s)) begin
        start  = 1'($urandom_range(0, 1));
        div_n  = 5'($urandom);
        pulses = 8'($urandom);
      end
      stop = (s > 0 && k + 1 == s);
      step();
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Directed bursts
    burst("d5p3", 5, 3, 0, 1'b0);
    burst("d1p2", 1, 2, 0, 1'b0);
    burst("stop_d4p5", 4, 5, 12, 1'b0);
    burst("max_div", 31, 1, 0, 1'b0);

    // Rejected start: div_n == 0
    div_n = 5'd0; pulses = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    chk_all("rej_div0", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk_all("rej_div0_after", 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef JK_DIV_CONT_EN
    burst("cont", 2, 0, 23, 1'b0);
`else
    div_n = 5'd3; pulses = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk_all("rej_p0", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk_all("rej_p0_after", 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // start together with stop in IDLE does nothing
    div_n = 5'd2; pulses = 8'd2; start = 1'b1; stop = 1'b1;
    step();
    chk_all("start_stop_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b0; stop = 1'b0;
    step();
    chk_all("start_stop_idle2", 1'b0, 1'b0, 1'b0, 1'b0);

    // Burst with start pulses and config changes mid-run
    burst("noise_d3p3", 3, 3, 0, 1'b1);

    // Reset mid-burst at E0+7
    div_n = 5'd3; pulses = 8'd4; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 7; k++) step();
    chk_all("pre_rst", 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_all("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      chk_all($sformatf("post_rst%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Randomized bursts, some aborted, some with interference
    for (int i = 0; i < 25; i++) begin
      int d, p, s;
      d = $urandom_range(1, 6);
      p = $urandom_range(1, 4);
      s = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2 * d * p - 1) : 0;
      burst($sformatf("rnd%0d", i), d, p, s, 1'($urandom_range(0, 1)));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        step();
        chk_all($sformatf("gap%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
